// File: rtl/skid_buf_pkg.sv
// Shared types and helpers for the two-entry skid buffer.
package skid_buf_pkg;

    // Occupancy of the slice: 0, 1 or 2 buffered beats.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Output side has a beat to present.
    function automatic logic skid_has_data(input skid_state_t s);
        return (s == SKID_BUSY) || (s == SKID_FULL);
    endfunction

    // Input side has room for another beat.
    function automatic logic skid_can_accept(input skid_state_t s);
        return (s != SKID_FULL);
    endfunction

endpackage

// File: rtl/skid_buf_dffse.sv
// Enabled data register with synchronous active-high reset to INIT.
module dffse #(
    parameter int unsigned    W    = 1,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Reset dominates; otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= INIT;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/skid_buf.sv
// Two-entry valid/ready register slice. in_rdy, out_vld and out_dat all come
// straight from flops, so no combinational path crosses the slice.
module skid_buf
    import skid_buf_pkg::*;
#(
    parameter int unsigned  W    = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    skid_state_t  state_q, state_d;
    logic         in_rdy_q, in_rdy_d;
    logic         out_vld_q, out_vld_d;

    logic         in_fire;
    logic         out_fire;

    logic         main_en;
    logic         main_from_skid;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;

    logic         skid_en;
    logic [W-1:0] skid_q;

    // Handshakes use the registered ready/valid, never out_rdy -> in_rdy.
    assign in_fire  = in_vld & in_rdy_q;
    assign out_fire = out_vld_q & out_rdy;

    // Next-state and register-enable decode.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;

        unique case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    state_d = SKID_BUSY;
                    main_en = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (in_fire && !out_fire) begin
                    // Consumer stalled: park the new beat behind the head.
                    state_d = SKID_FULL;
                    skid_en = 1'b1;
                end else if (!in_fire && out_fire) begin
                    state_d = SKID_EMPTY;
                end else if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end
            end
            SKID_FULL: begin
                // in_rdy is low here, so in_vld cannot fire.
                if (out_fire) begin
                    state_d        = SKID_BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    // Head register reloads from the skid when draining FULL.
    always_comb begin
        main_d = main_from_skid ? skid_q : in_dat;
    end

    // Flag registers are decoded from next-state so they line up with it.
    always_comb begin
        in_rdy_d  = skid_can_accept(state_d);
        out_vld_d = skid_has_data(state_d);
    end

    // State and handshake flags, synchronous reset to EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SKID_EMPTY;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    dffse #(
        .W    (W),
        .INIT (INIT)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    dffse #(
        .W    (W),
        .INIT (INIT)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_dat),
        .q   (skid_q)
    );

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign out_dat = main_q;

    // FULL always presents a beat.
    a_full_has_vld: assert property (@(posedge clk) disable iff (rst)
        (state_q == SKID_FULL) |-> out_vld_q);

    // The slice is never both unable to accept and empty.
    a_never_dead: assert property (@(posedge clk) disable iff (rst)
        ({in_rdy_q, out_vld_q} != 2'b00));

endmodule

// File: tb/tb_skid_buf.sv
// Self-checking bench for skid_buf against a two-deep queue model.
module tb_skid_buf;

    localparam int unsigned  W    = 8;
    localparam logic [W-1:0] INIT = 8'hC3;

    logic         clk;
    logic         rst;
    logic         in_vld;
    logic [W-1:0] in_dat;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_dat;
    logic         out_rdy;

    int checks;
    int errors;

    // Reference model: ordered list of buffered beats, at most two.
    logic [W-1:0] mq[$];

    skid_buf #(
        .W    (W),
        .INIT (INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_rdy (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model applies the handshake rules to the inputs
    // as driven before the edge. Outputs are observed 1 ns after the edge.
    task automatic tick();
        bit           acc;
        bit           dlv;
        logic [W-1:0] d;
        acc = (in_vld === 1'b1) && (mq.size() < 2);
        dlv = (out_rdy === 1'b1) && (mq.size() > 0);
        d   = in_dat;
        @(posedge clk);
        #1;
        if (rst === 1'b1) begin
            mq.delete();
        end else begin
            if (dlv) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; in_dat = 8'h11; out_rdy = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_vld !== 1'b0) begin
            errors++; $display("FAIL reset_out_vld: got %b want 0", out_vld);
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
        end
        checks++;
        if (out_dat !== INIT) begin
            errors++; $display("FAIL reset_out_dat: got %h want %h", out_dat, INIT);
        end
        rst = 1'b0; in_vld = 1'b0;
        tick();
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_dat !== INIT) begin
            errors++;
            $display("FAIL reset_release: got vld=%b rdy=%b dat=%h want vld=0 rdy=1 dat=%h",
                     out_vld, in_rdy, out_dat, INIT);
        end
    endtask

    task automatic test_streaming();
        out_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_vld = 1'b1;
            in_dat = W'(i);
            checks++;
            if (in_rdy !== 1'b1) begin
                errors++; $display("FAIL stream_in_rdy[%0d]: got %b want 1", i, in_rdy);
            end
            tick();
            checks++;
            if (out_vld !== 1'b1 || out_dat !== W'(i)) begin
                errors++;
                $display("FAIL stream_out[%0d]: got vld=%b dat=%h want vld=1 dat=%h",
                         i, out_vld, out_dat, W'(i));
            end
        end
        in_vld = 1'b0;
        tick();
        checks++;
        if (out_vld !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got vld=%b want 0", out_vld);
        end
    endtask

    task automatic test_skid();
        out_rdy = 1'b0; in_vld = 1'b1; in_dat = 8'hA0;
        tick();
        in_dat = 8'hA1;
        tick();
        in_dat = 8'hA2;
        tick();
        checks++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b1 || out_dat !== 8'hA0) begin
            errors++;
            $display("FAIL skid_full: got rdy=%b vld=%b dat=%h want rdy=0 vld=1 dat=a0",
                     in_rdy, out_vld, out_dat);
        end
        out_rdy = 1'b1;
        tick();
        checks++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b1 || out_dat !== 8'hA1) begin
            errors++;
            $display("FAIL skid_drain1: got rdy=%b vld=%b dat=%h want rdy=1 vld=1 dat=a1",
                     in_rdy, out_vld, out_dat);
        end
        tick();
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b1 || out_dat !== 8'hA2) begin
            errors++;
            $display("FAIL skid_drain2: got vld=%b dat=%h want vld=1 dat=a2", out_vld, out_dat);
        end
        tick();
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL skid_empty: got vld=%b rdy=%b want vld=0 rdy=1", out_vld, in_rdy);
        end
    endtask

    task automatic test_stall();
        out_rdy = 1'b0; in_vld = 1'b1; in_dat = 8'h55;
        tick();
        in_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_vld !== 1'b1 || out_dat !== 8'h55 || in_rdy !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: got vld=%b dat=%h rdy=%b want vld=1 dat=55 rdy=1",
                         i, out_vld, out_dat, in_rdy);
            end
        end
        out_rdy = 1'b1;
        tick();
        checks++;
        if (out_vld !== 1'b0) begin
            errors++; $display("FAIL stall_release: got vld=%b want 0", out_vld);
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0; in_vld = 1'b1; in_dat = 8'h31;
        tick();
        in_dat = 8'h32;
        tick();
        in_vld = 1'b0;
        checks++;
        if (in_rdy !== 1'b0) begin
            errors++; $display("FAIL midrst_full: got rdy=%b want 0", in_rdy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear: got vld=%b rdy=%b want vld=0 rdy=1", out_vld, in_rdy);
        end
        in_vld = 1'b1; in_dat = 8'h77;
        tick();
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b1 || out_dat !== 8'h77) begin
            errors++;
            $display("FAIL midrst_new: got vld=%b dat=%h want vld=1 dat=77", out_vld, out_dat);
        end
        out_rdy = 1'b1;
        tick();
        checks++;
        if (out_vld !== 1'b0) begin
            errors++; $display("FAIL midrst_stale: got vld=%b dat=%h want vld=0", out_vld, out_dat);
        end
    endtask

    task automatic test_random();
        logic r0;
        logic r1;
        int   bad;
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            rst     = ($urandom_range(0, 999) == 0);
            in_vld  = ($urandom_range(0, 3) != 0);
            in_dat  = W'($urandom);
            out_rdy = 1'b0;
            #1;
            r0 = in_rdy;
            out_rdy = 1'b1;
            #1;
            r1 = in_rdy;
            out_rdy = ($urandom_range(0, 2) != 0);
            checks++;
            if (r0 !== r1) begin
                errors++;
                $display("FAIL rand_comb_path[%0d]: in_rdy %b with out_rdy=0, %b with out_rdy=1",
                         c, r0, r1);
            end
            tick();
            checks++;
            if (in_rdy !== (mq.size() < 2) || out_vld !== (mq.size() > 0)) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_flags[%0d]: got rdy=%b vld=%b want rdy=%b vld=%b",
                             c, in_rdy, out_vld, mq.size() < 2, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++;
                if (out_dat !== mq[0]) begin
                    errors++; bad++;
                    if (bad < 10)
                        $display("FAIL rand_data[%0d]: got %h want %h", c, out_dat, mq[0]);
                end
            end
        end
        rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rand_final: got vld=%b rdy=%b want vld=0 rdy=1", out_vld, in_rdy);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_dat  = '0;
        out_rdy = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
